// File: rtl/motor_driver.sv
// Purpose: wheel PWM/direction driver for the wall-follower, with dead time on FWD<->ROT reversal.
// Latency: all outputs registered, visible one cycle after the edge that samples Front/Rotate.
// Backpressure: none; commands are level inputs sampled every edge. Option macro: MOTOR_DRIVER_SOFT_START_EN.
module motor_driver #(
    parameter int PWM_PERIOD = 8,
    parameter int DEAD_TIME  = 3,
    parameter int RAMP_STEP  = 2
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic Front,
    input  logic Rotate,
    output logic LeftPwm,
    output logic RightPwm,
    output logic LeftDir,
    output logic RightDir,
    output logic Fault
);

    localparam int CW = $clog2(PWM_PERIOD + 1);
    localparam logic [CW-1:0] PERIOD_W = CW'(PWM_PERIOD);
    localparam logic [CW-1:0] LAST_CNT = CW'(PWM_PERIOD - 1);
    localparam logic [7:0]    DEAD_W   = 8'(DEAD_TIME);

    // Reject out-of-range configurations at elaboration
    if (PWM_PERIOD < 2 || PWM_PERIOD > 255 || DEAD_TIME < 1 || DEAD_TIME > 255 ||
        RAMP_STEP < 1 || RAMP_STEP > PWM_PERIOD) begin : g_bad_cfg
        $error("motor_driver: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DEAD  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          rot_q, rot_d;        // latched command: 1 = ROT, 0 = FWD
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] duty_q, duty_d;
    logic [7:0]    dead_q, dead_d;
    logic          pwm_q, pwm_d;
    logic          ldir_q, ldir_d;
    logic          rdir_q, rdir_d;
    logic          fault_q, fault_d;

    logic          cmd_fwd, cmd_rot, cmd_go;
    logic          enter;
    logic [CW-1:0] duty_init;
    logic [CW-1:0] duty_wrap;           // duty to use after a counter wrap

    assign cmd_fwd = Front & ~Rotate;
    assign cmd_rot = Rotate & ~Front;
    assign cmd_go  = cmd_fwd | cmd_rot;  // 11 decodes as STOP

`ifdef MOTOR_DRIVER_SOFT_START_EN
    logic [CW:0] duty_sum;
    // Ramp duty by RAMP_STEP per period, saturating at full on
    always_comb begin
        duty_sum  = {1'b0, duty_q} + (CW+1)'(RAMP_STEP);
        duty_init = '0;
        duty_wrap = (duty_sum > {1'b0, PERIOD_W}) ? PERIOD_W : duty_sum[CW-1:0];
    end
`else
    // Full duty from the first cycle in DRIVE
    always_comb begin
        duty_init = PERIOD_W;
        duty_wrap = duty_q;
    end
`endif

    // Next-state and next-output logic; outputs reflect the state being entered
    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        dead_d  = dead_q;
        ldir_d  = ldir_q;
        rdir_d  = rdir_q;
        fault_d = Front & Rotate;
        enter   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_go) enter = 1'b1;
            end
            DRIVE: begin
                if (cmd_go && (cmd_rot == rot_q)) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d  = '0;
                        duty_d = duty_wrap;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cmd_go) begin
                    state_d = DEAD;
                    dead_d  = DEAD_W;
                end else begin
                    state_d = IDLE;
                end
            end
            DEAD: begin
                // Last dead cycle: only the command seen now decides the exit
                if (dead_q <= 8'd1) begin
                    dead_d = '0;
                    if (cmd_go) enter = 1'b1;
                    else        state_d = IDLE;
                end else begin
                    dead_d = dead_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter) begin
            state_d = DRIVE;
            rot_d   = cmd_rot;
            cnt_d   = '0;
            duty_d  = duty_init;
            ldir_d  = 1'b1;
            rdir_d  = ~cmd_rot;
        end

        if (state_d != DRIVE) begin
            cnt_d  = '0;
            duty_d = '0;
        end

        pwm_d = (state_d == DRIVE) && (cnt_d < duty_d);
    end

    // State and output registers, forced to safe values by async reset
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            rot_q   <= 1'b0;
            cnt_q   <= '0;
            duty_q  <= '0;
            dead_q  <= '0;
            pwm_q   <= 1'b0;
            ldir_q  <= 1'b1;
            rdir_q  <= 1'b1;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            dead_q  <= dead_d;
            pwm_q   <= pwm_d;
            ldir_q  <= ldir_d;
            rdir_q  <= rdir_d;
            fault_q <= fault_d;
        end
    end

    assign LeftPwm  = pwm_q;
    assign RightPwm = pwm_q;
    assign LeftDir  = ldir_q;
    assign RightDir = rdir_q;
    assign Fault    = fault_q;

endmodule

// File: tb/tb_motor_driver.sv
// Purpose: random and directed stimulus for motor_driver, checked against a time-based reference model.
// Latency: model outputs are compared at the falling edge after each sampling edge.
// Backpressure: not applicable; every cycle carries a command.
module tb_motor_driver;

    localparam int P  = 8;
    localparam int DT = 3;
    localparam int RS = 2;

    logic Clock = 1'b0;
    logic Reset_n;
    logic Front;
    logic Rotate;
    logic LeftPwm, RightPwm, LeftDir, RightDir, Fault;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 idle, 1 drive, 2 dead; drive output derived from time since entry
    int m_mode;
    int m_cur;
    int m_age;
    int m_left;
    bit m_ld, m_rd, m_fault;

    motor_driver #(.PWM_PERIOD(P), .DEAD_TIME(DT), .RAMP_STEP(RS)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Front   (Front),
        .Rotate  (Rotate),
        .LeftPwm (LeftPwm),
        .RightPwm(RightPwm),
        .LeftDir (LeftDir),
        .RightDir(RightDir),
        .Fault   (Fault)
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int duty_of(input int period_idx);
`ifdef MOTOR_DRIVER_SOFT_START_EN
        return (period_idx * RS > P) ? P : period_idx * RS;
`else
        return P;
`endif
    endfunction

    function automatic logic [7:0] model_out();
        logic pwm;
        pwm = (m_mode == 1) && ((m_age % P) < duty_of(m_age / P));
        return {3'b000, pwm, pwm, m_ld, m_rd, m_fault};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cur = 0; m_age = 0; m_left = 0;
        m_ld = 1'b1; m_rd = 1'b1; m_fault = 1'b0;
    endtask

    task automatic model_enter(input int c);
        m_mode = 1; m_cur = c; m_age = 0;
        m_ld = 1'b1; m_rd = (c == 2);
    endtask

    // c = {Front,Rotate}: 2 FWD, 1 ROT, 0 STOP, 3 illegal (STOP + Fault)
    task automatic model_step(input int c);
        bit go;
        go = (c == 1) || (c == 2);
        m_fault = (c == 3);
        case (m_mode)
            0: if (go) model_enter(c);
            1: begin
                if (c == m_cur)  m_age++;
                else if (go)     begin m_mode = 2; m_left = DT; end
                else             m_mode = 0;
            end
            default: begin
                if (m_left == 1) begin
                    if (go) model_enter(c);
                    else    m_mode = 0;
                end else begin
                    m_left--;
                end
            end
        endcase
    endtask

    function automatic logic [7:0] dut_out();
        return {3'b000, LeftPwm, RightPwm, LeftDir, RightDir, Fault};
    endfunction

    // Apply a command at the falling edge, let one rising edge sample it, compare at the next falling edge
    task automatic cycle(input int c, input string tag);
        Front  = (c >= 2);
        Rotate = (c % 2) == 1;
        @(posedge Clock);
        model_step(c);
        @(negedge Clock);
        check_eq(tag, dut_out(), model_out());
    endtask

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int c;
        int len;
        Reset_n = 1'b0;
        Front   = 1'b0;
        Rotate  = 1'b0;
        model_reset();
        repeat (2) @(negedge Clock);
        check_eq("reset_vals", dut_out(), 8'b0000_0110);
        Reset_n = 1'b1;

        // FWD held across several PWM periods
        for (int i = 0; i < 6 * P; i++) cycle(2, "fwd_hold");

        // FWD -> ROT: direction flips after exactly DT dead cycles
        cycle(1, "fwd_to_rot");
        n = (RightDir == 1'b1) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, "rot_dead");
            if (RightDir == 1'b1) n++;
            else break;
        end
        check_eq("dead_len", 8'(n), 8'(DT));
        for (int i = 0; i < 2 * P; i++) cycle(1, "rot_hold");

        // Back to FWD, then ROT->STOP->FWD inside the dead window
        cycle(2, "rot_to_fwd");
        for (int i = 0; i < DT + 4; i++) cycle(2, "fwd_again");
        cycle(1, "dead_rot");
        cycle(0, "dead_stop");
        cycle(2, "dead_fwd");
        for (int i = 0; i < P; i++) cycle(2, "dead_exit_fwd");

        // Illegal command during DRIVE
        cycle(3, "fault_in");
        check_eq("fault_flag", {7'b0, Fault}, 8'd1);
        check_eq("fault_pwm", {6'b0, LeftPwm, RightPwm}, 8'd0);
        cycle(0, "fault_clear");
        check_eq("fault_low", {7'b0, Fault}, 8'd0);

        // Asynchronous reset between edges mid-DRIVE
        for (int i = 0; i < P + 3; i++) cycle(2, "pre_rst");
        #2 Reset_n = 1'b0;
        #1 check_eq("async_rst", dut_out(), 8'b0000_0110);
        model_reset();
        @(posedge Clock);
        @(negedge Clock);
        check_eq("rst_held", dut_out(), 8'b0000_0110);
        Front   = 1'b1;
        Rotate  = 1'b0;
        Reset_n = 1'b1;
        cycle(2, "first_after_rst");
        check_eq("first_dir", {6'b0, LeftDir, RightDir}, 8'd3);

        // Randomized command segments
        for (int s = 0; s < 80; s++) begin
            n   = $urandom_range(0, 9);
            c   = (n < 2) ? 0 : (n < 5) ? 2 : (n < 8) ? 1 : (n == 8) ? 3 : 0;
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) cycle(c, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motor_driver.md
MOTOR_DRIVER -- requirements
Module: motor_driver

Interface
REQ-001 The block SHALL have parameter PWM_PERIOD, default 8, giving the PWM period in Clock cycles (legal range 2..255).
REQ-002 The block SHALL have parameter DEAD_TIME, default 3, giving the Clock cycles both wheels are held off on a direction change (legal range 1..255).
REQ-003 The block SHALL have parameter RAMP_STEP, default 2, giving the duty increment per PWM period in soft start (legal range 1..PWM_PERIOD).
REQ-004 The block SHALL have port Clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port Reset_n, input, 1 bit, reset, asynchronous and active-low.
REQ-006 The block SHALL have port Front, input, 1 bit, the drive-forward command from the wall-follower FSM.
REQ-007 The block SHALL have port Rotate, input, 1 bit, the rotate-in-place command from the wall-follower FSM.
REQ-008 The block SHALL have ports LeftPwm and RightPwm, outputs, 1 bit each, the wheel enable PWM.
REQ-009 The block SHALL have ports LeftDir and RightDir, outputs, 1 bit each, the wheel direction: 1 = forward, 0 = reverse.
REQ-010 The block SHALL have port Fault, output, 1 bit, high while an illegal command (Front=Rotate=1) is sampled.

Function
REQ-011 The block SHALL decode {Front,Rotate} every rising edge: 10 = FWD, 01 = ROT, 00 = STOP, 11 = STOP with Fault=1.
REQ-012 The FSM SHALL have states IDLE, DRIVE and DEAD; all outputs SHALL be registered, with a 1-cycle latency from the sampling edge.
REQ-013 IDLE: PWMs 0; on FWD or ROT -> DRIVE, latch the command, PWM counter=0, duty per REQ-020.
REQ-014 DRIVE, same command as latched: stay in DRIVE; on STOP -> IDLE.
REQ-015 DRIVE, opposite command (FWD<->ROT): -> DEAD, dead counter=DEAD_TIME, PWMs 0 from the next cycle.
REQ-016 DEAD: PWMs 0; decrement each cycle; at 0, sample the command: FWD/ROT -> DRIVE (latch, restart the PWM counter and duty); STOP -> IDLE.
REQ-017 Dir outputs SHALL update only on entry to DRIVE and SHALL otherwise hold their value: FWD gives LeftDir=1, RightDir=1; ROT gives LeftDir=1, RightDir=0.
REQ-018 In DRIVE the PWM counter SHALL count 0..PWM_PERIOD-1 and wrap; LeftPwm=RightPwm=(counter<duty).
REQ-019 Duty SHALL be at most PWM_PERIOD; counter and duty width SHALL be clog2(PWM_PERIOD+1).
REQ-020 Duty on DRIVE entry SHALL be set per the Configuration section.
REQ-021 A command change in DEAD SHALL NOT restart the dead counter; only the command at expiry matters.
REQ-022 If Fault is sampled in any state, the FSM SHALL treat it as STOP (DEAD continues to expiry).

Reset
REQ-023 While Reset_n=0: state IDLE; counters and duty 0; LeftPwm=RightPwm=0; LeftDir=RightDir=1; Fault=0.
REQ-024 Reset asserted mid-DRIVE or mid-DEAD SHALL force the REQ-023 values immediately, without waiting for Clock.
REQ-025 The first command SHALL be sampled on the first rising edge after Reset_n rises.

Configuration
REQ-026 With macro MOTOR_DRIVER_SOFT_START_EN defined, duty SHALL be 0 on DRIVE entry and, at each counter wrap, SHALL become min(duty+RAMP_STEP, PWM_PERIOD).
REQ-027 Without MOTOR_DRIVER_SOFT_START_EN, duty SHALL be PWM_PERIOD on DRIVE entry (PWMs constantly 1 in DRIVE), and RAMP_STEP SHALL be ignored.

Verification
REQ-028 Scenario: reset, then FWD held (soft start off) -> from the 2nd edge LeftPwm=RightPwm=1 continuously, LeftDir=RightDir=1.
REQ-029 Scenario: soft start on, FWD held -> high cycles per 8-cycle period are 0,2,4,6,8,8.
REQ-030 Scenario: FWD, then ROT -> PWMs 0 for exactly 3 cycles, then RightDir=0 and PWM resumes.
REQ-031 Scenario: in DEAD, ROT->STOP->FWD before expiry -> DRIVE with FWD after exactly 3 cycles, no restart.
REQ-032 Scenario: Front=Rotate=1 during DRIVE -> Fault=1 next cycle, PWMs 0, IDLE; returning to 00 -> Fault=0.
REQ-033 Scenario: Reset_n low between clock edges mid-DRIVE -> all outputs at reset values before the next edge.
